msg_framer: RTL and testbench

Parametrised successor to the command encoder: collects pending response messages from N_SRC slave interfaces, arbitrates round-robin, and serialises each message as a framed byte stream onto the UART transmit AXI-stream. Compared with the current encoder it adds:
- sync byte and address offset
- optional checksum
- starvation timeout with zero padding and an error flag
- fair arbitration

It sits between the slave data/len/have_msg buses and the `uart` input stream.

---
 rtl/msg_framer.sv | 248 ++++++++++++++++++++++++
 tb/tb_msg_framer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_framer.sv
// msg_framer: collects pending response messages from N_SRC sources, picks
// one round-robin and serialises it as a framed byte stream onto a
// valid/ready byte stream (the UART transmit input).
//
// Frame: SYNC_BYTE, ADDR (= source index + ADDR_OFFSET mod 256), LEN,
// LEN payload bytes (LEN 0 means 256), then CHK when CHK_EN=1. CHK is the
// 8-bit sum of ADDR, LEN and every payload byte, pads included.
//
// Ports:
//   clk, n_rst           clock, asynchronous active-low reset
//   have_msg_bus[i]      source i has a message / next byte available
//   data_bus[8*i+:8]     source i current byte (show-ahead)
//   len_bus[8*i+:8]      source i message length, sampled at grant only
//   rdreq_bus[i]         one-cycle pop strobe to source i (one-hot or zero)
//   tx_data/tx_valid/tx_ready  output byte stream
//   busy                 frame in progress (grant through final handshake)
//   cur_src              index of the granted source
//   err_underrun         one-cycle pulse when timeout padding starts
module msg_framer #(
  parameter int unsigned N_SRC       = 25,
  parameter int unsigned ADDR_OFFSET = 0,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter bit          CHK_EN      = 1'b1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [7:0]         cur_src,
  output logic               err_underrun
);

  localparam int unsigned SW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [7:0]  OFS = 8'(ADDR_OFFSET % 256);
  localparam logic [16:0] TMO = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SYNC, S_ADDR, S_LEN, S_PLOAD, S_PWAIT, S_CHK
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  cur_q, cur_d;
  logic [SW-1:0]  last_q, last_d;
  logic [7:0]     len_q, len_d;
  logic [8:0]     rem_q, rem_d;
  logic [7:0]     chk_q, chk_d;
  logic [15:0]    wait_q, wait_d;
  logic           pad_q, pad_d;
  logic [7:0]     txd_q, txd_d;
  logic           txv_q, txv_d;
  logic           err_q, err_d;

  logic [7:0]     data_arr [N_SRC];
  logic [7:0]     len_arr  [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_slot
    assign data_arr[i] = data_bus[8*i +: 8];
    assign len_arr[i]  = len_bus[8*i +: 8];
  end

  // Round-robin pick: first pending source strictly after the last grant.
  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  int unsigned   j;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      j = (32'(last_q) + k) % N_SRC;
      if (!gnt_found && have_msg_bus[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(j);
      end
    end
  end

  logic        hs;
  logic [16:0] wait_inc;
  logic [7:0]  len_g;

  assign hs       = txv_q & tx_ready;
  assign wait_inc = {1'b0, wait_q} + 17'd1;
  assign len_g    = len_arr[gnt_idx];

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    len_d     = len_q;
    rem_d     = rem_q;
    chk_d     = chk_q;
    wait_d    = wait_q;
    pad_d     = pad_q;
    txd_d     = txd_q;
    txv_d     = txv_q;
    err_d     = 1'b0;
    rdreq_bus = '0;

    unique case (state_q)
      S_IDLE: if (|have_msg_bus) state_d = S_ARB;

      S_ARB: begin
        if (gnt_found) begin
          cur_d   = gnt_idx;
          len_d   = len_g;
          rem_d   = (len_g == 8'd0) ? 9'd256 : {1'b0, len_g};
          chk_d   = 8'd0;
          wait_d  = '0;
          pad_d   = 1'b0;
          state_d = S_SYNC;
        end else begin
          // request vanished between IDLE and ARB
          state_d = S_IDLE;
        end
      end

      // Header bytes: the first cycle in the state loads, then hold until taken.
      S_SYNC: begin
        if (!txv_q) begin
          txd_d = SYNC_BYTE;
          txv_d = 1'b1;
        end else if (tx_ready) begin
          txv_d   = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (!txv_q) begin
          txd_d = 8'(cur_q) + OFS;
          txv_d = 1'b1;
        end else if (tx_ready) begin
          txv_d   = 1'b0;
          chk_d   = chk_q + txd_q;
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (!txv_q) begin
          txd_d = len_q;
          txv_d = 1'b1;
        end else if (tx_ready) begin
          txv_d   = 1'b0;
          chk_d   = chk_q + txd_q;
          state_d = S_PLOAD;
        end
      end

      S_PLOAD: begin
        if (pad_q) begin
          txd_d   = 8'h00;
          txv_d   = 1'b1;
          state_d = S_PWAIT;
        end else if (have_msg_bus[cur_q]) begin
          txd_d            = data_arr[cur_q];
          txv_d            = 1'b1;
          rdreq_bus[cur_q] = 1'b1;
          wait_d           = '0;
          state_d          = S_PWAIT;
        end else if (wait_inc >= TMO) begin
          // starved: pad this and every remaining byte with zero
          err_d   = 1'b1;
          pad_d   = 1'b1;
          txd_d   = 8'h00;
          txv_d   = 1'b1;
          wait_d  = '0;
          state_d = S_PWAIT;
        end else begin
          wait_d = wait_inc[15:0];
        end
      end

      S_PWAIT: begin
        if (hs) begin
          txv_d = 1'b0;
          chk_d = chk_q + txd_q;
          rem_d = rem_q - 9'd1;
          if (rem_q != 9'd1) begin
            state_d = S_PLOAD;
          end else if (CHK_EN) begin
            state_d = S_CHK;
          end else begin
            last_d  = cur_q;
            state_d = S_IDLE;
          end
        end
      end

      S_CHK: begin
        if (!txv_q) begin
          txd_d = chk_q;
          txv_d = 1'b1;
        end else if (tx_ready) begin
          txv_d   = 1'b0;
          last_d  = cur_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= SW'(N_SRC - 1);
      len_q   <= '0;
      rem_q   <= '0;
      chk_q   <= '0;
      wait_q  <= '0;
      pad_q   <= 1'b0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      chk_q   <= chk_d;
      wait_q  <= wait_d;
      pad_q   <= pad_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  assign tx_data      = txd_q;
  assign tx_valid     = txv_q;
  assign busy         = (state_q != S_IDLE);
  assign cur_src      = 8'(cur_q);
  assign err_underrun = err_q;

endmodule

// File: tb/tb_msg_framer.sv
// Bench for msg_framer: a queue-based source model feeds the DUT, and a
// frame-level reference (round-robin pick over pending sources, payload
// popped from per-source queues, zero pads when a queue runs dry, 8-bit sum)
// predicts every transmitted byte, rdreq count and underrun pulse count.
module tb_msg_framer;
  localparam int N         = 5;
  localparam int OFS       = 8'hFE;
  localparam int TMO       = 16;
  localparam logic [7:0] SY = 8'hA5;

  logic           clk = 1'b0;
  logic           n_rst = 1'b1;
  logic [N-1:0]   have_msg_bus;
  logic [8*N-1:0] data_bus, len_bus;
  logic [N-1:0]   rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, busy, err_underrun;
  logic [7:0]     cur_src;

  msg_framer #(.N_SRC(N), .ADDR_OFFSET(OFS), .SYNC_BYTE(SY), .CHK_EN(1'b1),
               .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .data_bus(data_bus),
    .len_bus(len_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .cur_src(cur_src),
    .err_underrun(err_underrun));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic [7:0] drvq [N][$];   // what each source still holds
  logic [7:0] mdlq [N][$];   // reference view of the same, popped per frame
  logic [7:0] len_r [N];
  logic [7:0] expq [$];

  int mlast = N - 1, pop_pend = -1, fbyte = 0, fr_rd = 0, fr_err = 0;
  int exp_rd = 0, exp_err = 0, pad_at = -1, gap = 0, vcnt = 0, rdy_mode = 0;
  logic       prev_valid = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int s, input logic [7:0] b);
    drvq[s].push_back(b);
    mdlq[s].push_back(b);
  endtask

  function automatic bit pending_any();
    for (int i = 0; i < N; i++) if (drvq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    if (pop_pend >= 0) begin
      if (drvq[pop_pend].size() != 0) void'(drvq[pop_pend].pop_front());
      pop_pend = -1;
    end
    for (int i = 0; i < N; i++) begin
      have_msg_bus[i]     = (drvq[i].size() != 0);
      data_bus[8*i +: 8]  = (drvq[i].size() != 0) ? drvq[i][0] : 8'h00;
      len_bus[8*i +: 8]   = len_r[i];
    end
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (vcnt >= 10);
    endcase
  endtask

  // Reference for one frame, built when its first byte goes out.
  task automatic build_frame();
    int src, n;
    logic [7:0] b, sum, addr;
    src = -1;
    for (int k = 1; k <= N; k++) begin
      int jj;
      jj = (mlast + k) % N;
      if (src < 0 && mdlq[jj].size() != 0) src = jj;
    end
    if (src < 0) begin
      check("unexpected_frame", 1, 0);
      src = 0;
    end
    check("cur_src", cur_src, src);
    check("busy_in_frame", busy, 1);
    addr = 8'(src + OFS);
    n    = (len_r[src] == 8'd0) ? 256 : int'(len_r[src]);
    expq.push_back(SY);
    expq.push_back(addr);
    expq.push_back(len_r[src]);
    sum    = addr + len_r[src];
    exp_rd = 0;
    pad_at = -1;
    for (int k = 0; k < n; k++) begin
      if (mdlq[src].size() != 0) begin
        b = mdlq[src].pop_front();
        exp_rd++;
      end else begin
        b = 8'h00;
        if (pad_at < 0) pad_at = 3 + k;
      end
      expq.push_back(b);
      sum += b;
    end
    expq.push_back(sum);
    exp_err = (pad_at >= 0) ? 1 : 0;
    mlast   = src;
    fbyte   = 0;
    fr_rd   = 0;
    fr_err  = 0;
  endtask

  task automatic observe();
    logic hs;
    if (!n_rst) return;
    if (rdreq_bus != '0) begin
      check("rdreq_onehot", $countones(rdreq_bus), 1);
      for (int i = 0; i < N; i++)
        if (rdreq_bus[i]) begin
          check("rdreq_has_data", drvq[i].size() != 0, 1);
          pop_pend = i;
          fr_rd++;
        end
    end
    if (err_underrun) fr_err++;
    if (prev_valid && !prev_hs) begin
      check("valid_hold", tx_valid, 1);
      check("data_hold", tx_data, prev_data);
    end
    if (prev_hs) check("valid_gap", tx_valid, 0);
    if (tx_valid && !prev_valid && pad_at >= 0 && fbyte == pad_at)
      check("pad_wait", gap, TMO);
    gap = tx_valid ? 0 : gap + 1;
    hs = tx_valid && tx_ready;
    if (hs) begin
      if (expq.size() == 0) build_frame();
      check("byte", tx_data, expq.pop_front());
      fbyte++;
      if (expq.size() == 0) begin
        check("rdreq_cnt", fr_rd, exp_rd);
        check("err_cnt", fr_err, exp_err);
        pad_at = -1;
      end
    end
    vcnt       = (tx_valid && !hs) ? vcnt + 1 : 0;
    prev_valid = tx_valid;
    prev_hs    = hs;
    prev_data  = tx_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    step();
    while ((busy || expq.size() != 0 || pending_any()) && n < bound) begin
      step();
      n++;
    end
    check("idle_reached", n < bound, 1);
    check("busy_idle", busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid"}, tx_valid, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_rdreq"}, rdreq_bus, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cur"}, cur_src, 0);
    check({tag, "_err"}, err_underrun, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int lat, n;
    for (int i = 0; i < N; i++) len_r[i] = 8'd1;
    drive();
    #2 n_rst = 1'b0;
    #1 chk_reset("rst");
    repeat (2) step();
    n_rst = 1'b1;
    repeat (2) step();

    // single frame, address offset wraps, latency to first valid
    len_r[3] = 8'd2;
    push_byte(3, 8'h11);
    push_byte(3, 8'h22);
    step();
    lat = 0;
    while (!tx_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", lat, 3);
    wait_idle(200);

    // round robin over three held sources
    for (int i = 0; i < 3; i++) begin
      len_r[i] = 8'd1;
      push_byte(i, 8'(8'h30 + i));
      push_byte(i, 8'(8'h40 + i));
    end
    wait_idle(500);

    // LEN=0 means 256 bytes
    len_r[4] = 8'd0;
    for (int k = 0; k < 256; k++) push_byte(4, 8'(k));
    wait_idle(2000);

    // starvation: only 2 of 4 bytes ever arrive
    len_r[1] = 8'd4;
    push_byte(1, 8'h5A);
    push_byte(1, 8'hC3);
    wait_idle(500);

    // backpressure: ready held low ~10 cycles per byte
    rdy_mode = 2;
    len_r[2] = 8'd3;
    push_byte(2, 8'h01);
    push_byte(2, 8'h80);
    push_byte(2, 8'hFF);
    wait_idle(500);

    // random traffic
    for (int it = 0; it < 6; it++) begin
      rdy_mode = $urandom_range(0, 1);
      for (int i = 0; i < N; i++) begin
        len_r[i] = 8'($urandom_range(1, 6));
        n = $urandom_range(0, 2) * int'(len_r[i]);
        for (int k = 0; k < n; k++) push_byte(i, 8'($urandom));
      end
      wait_idle(3000);
    end

    // reset during payload byte 3 of 5
    rdy_mode = 0;
    len_r[3] = 8'd5;
    for (int k = 0; k < 5; k++) push_byte(3, 8'(8'h60 + k));
    n = 0;
    step();
    while (!(fbyte == 6 && tx_valid && expq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("reach_payload3", n < 200, 1);
    #3 n_rst = 1'b0;
    #1 chk_reset("midrst");
    drvq[3].delete();
    mdlq[3].delete();
    expq.delete();
    mlast = N - 1; pop_pend = -1; fbyte = 0; pad_at = -1; gap = 0; vcnt = 0;
    prev_valid = 1'b0; prev_hs = 1'b0;
    for (int k = 0; k < 5; k++) push_byte(3, 8'(8'h70 + k));
    repeat (2) step();
    n_rst = 1'b1;
    wait_idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
